// File: rtl/spwm_table_reader_pkg.sv
// Shared widths, default constants and carrier direction type for the SPWM table reader.
package spwm_table_reader_pkg;

  localparam int unsigned TABLE_ADDR_W    = 10;
  localparam int unsigned SAMPLE_W        = 13;
  localparam int unsigned CARRIER_MAX_DEF = 5000;
  localparam int unsigned TABLE_LAST_DEF  = 88;
  localparam int unsigned DEAD_TIME_DEF   = 10;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } carrier_dir_e;

endpackage

// File: rtl/spwm_deadtime.sv
// Complementary gate pair from a raw PWM level, with both gates held low for
// DEAD_TIME cycles after every raw edge.
module spwm_deadtime
  import spwm_table_reader_pkg::*;
#(
  parameter int unsigned DEAD_TIME = DEAD_TIME_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic gate_hi,
  output logic gate_lo
);

  localparam int unsigned CNT_W = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             raw_q;

  // A raw edge restarts the window; otherwise count down and stick at zero.
  always_comb begin
    cnt_next = cnt;
    if (raw != raw_q) begin
      cnt_next = CNT_W'(DEAD_TIME);
    end else if (cnt != '0) begin
      cnt_next = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= CNT_W'(DEAD_TIME);
      raw_q   <= 1'b0;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
    end else if (!en) begin
      cnt     <= CNT_W'(DEAD_TIME);
      raw_q   <= raw;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      raw_q <= raw;
      if (cnt_next == '0) begin
        gate_hi <= raw;
        gate_lo <= ~raw;
      end else begin
        gate_hi <= 1'b0;
        gate_lo <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spwm_table_reader.sv
// Half-sine table reader: triangle carrier, address sequencer, registered
// reference and compare feeding the dead-time gate stage.
module spwm_table_reader
  import spwm_table_reader_pkg::*;
#(
  parameter int unsigned CARRIER_MAX = CARRIER_MAX_DEF,
  parameter int unsigned TABLE_LAST  = TABLE_LAST_DEF,
  parameter int unsigned DEAD_TIME   = DEAD_TIME_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [TABLE_ADDR_W-1:0] teth_ta,
  input  logic [SAMPLE_W-1:0]     sine_in,
  output logic                    gate_hi,
  output logic                    gate_lo,
  output logic                    polarity,
  output logic                    period_done
);

  logic [SAMPLE_W-1:0] carrier;
  logic [SAMPLE_W-1:0] carrier_step;
  logic [SAMPLE_W-1:0] ref_q;
  carrier_dir_e        carrier_dir;
  logic                advance;
  logic                wrap;
  logic                raw;

  // Address steps at the carrier valley, i.e. once per full carrier period.
  always_comb begin
    carrier_step = (carrier_dir == UP) ? carrier + SAMPLE_W'(1) : carrier - SAMPLE_W'(1);
    advance      = en && (carrier_dir == DOWN) && (carrier == SAMPLE_W'(1));
    wrap         = advance && (teth_ta == TABLE_ADDR_W'(TABLE_LAST));
    raw          = ref_q > carrier;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carrier     <= '0;
      carrier_dir <= UP;
      ref_q       <= '0;
      teth_ta     <= '0;
      polarity    <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= 1'b0;
      if (en) begin
        carrier <= carrier_step;
        ref_q   <= sine_in;
        if (carrier_step == SAMPLE_W'(CARRIER_MAX)) begin
          carrier_dir <= DOWN;
        end else if (carrier_step == '0) begin
          carrier_dir <= UP;
        end
        // Full sine period ends when polarity returns from negative to positive.
        if (wrap) begin
          teth_ta     <= '0;
          polarity    <= ~polarity;
          period_done <= polarity;
        end else if (advance) begin
          teth_ta <= teth_ta + TABLE_ADDR_W'(1);
        end
      end
    end
  end

  spwm_deadtime #(
    .DEAD_TIME (DEAD_TIME)
  ) u_deadtime (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .raw     (raw),
    .gate_hi (gate_hi),
    .gate_lo (gate_lo)
  );

endmodule

// File: tb/tb_spwm_table_reader.sv
// Directed bench for spwm_table_reader with a small carrier (peak 8); one
// instance with 2-cycle dead-time and one with dead-time disabled.
module tb_spwm_table_reader;
  import spwm_table_reader_pkg::*;

  localparam int unsigned CMAX  = 8;
  localparam int unsigned TLAST = 88;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [9:0]  teth_ta,  teth_ta0;
  logic [12:0] sine_in,  sine_in0;
  logic        gate_hi,  gate_lo,  polarity,  period_done;
  logic        gate_hi0, gate_lo0, polarity0, period_done0;
  logic        force_mode;
  logic [12:0] force_val;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [12:0] lut(input logic [9:0] a);
    return 13'(int'(a) % 9);
  endfunction

  always_comb sine_in = force_mode ? force_val : lut(teth_ta);
  assign sine_in0 = 13'd4;

  spwm_table_reader #(.CARRIER_MAX(CMAX), .TABLE_LAST(TLAST), .DEAD_TIME(2)) dut (
    .clk(clk), .rst(rst), .en(en), .teth_ta(teth_ta), .sine_in(sine_in),
    .gate_hi(gate_hi), .gate_lo(gate_lo), .polarity(polarity), .period_done(period_done)
  );

  spwm_table_reader #(.CARRIER_MAX(CMAX), .TABLE_LAST(TLAST), .DEAD_TIME(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .teth_ta(teth_ta0), .sine_in(sine_in0),
    .gate_hi(gate_hi0), .gate_lo(gate_lo0), .polarity(polarity0), .period_done(period_done0)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int exp_c;
    rst = 1'b1; en = 1'b0; force_mode = 1'b0; force_val = '0;
    repeat (3) step();
    checks++;
    if (teth_ta !== 10'd0) begin errors++; $display("FAIL reset_ta: got %0d expected 0", teth_ta); end
    checks++;
    if ({gate_hi, gate_lo} !== 2'b00) begin errors++; $display("FAIL reset_gates: got %b expected 00", {gate_hi, gate_lo}); end
    checks++;
    if ({polarity, period_done} !== 2'b00) begin errors++; $display("FAIL reset_pol_pd: got %b expected 00", {polarity, period_done}); end
    checks++;
    if (dut.carrier !== 13'd0) begin errors++; $display("FAIL reset_carrier: got %0d expected 0", dut.carrier); end
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_c = (k <= 8) ? k : 16 - k;
      checks++;
      if (dut.carrier !== 13'(exp_c)) begin
        errors++; $display("FAIL carrier_seq k=%0d: got %0d expected %0d", k, dut.carrier, exp_c);
      end
      checks++;
      if (teth_ta !== ((k == 16) ? 10'd1 : 10'd0)) begin
        errors++; $display("FAIL ta_advance k=%0d: got %0d expected %0d", k, teth_ta, (k == 16) ? 1 : 0);
      end
    end
  endtask

  task automatic test_complementary();
    int hi_cnt = 0;
    int lo_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      hi_cnt += int'(gate_hi0);
      lo_cnt += int'(gate_lo0);
      checks++;
      if (gate_hi0 !== ~gate_lo0) begin
        errors++; $display("FAIL compl_pair i=%0d: got hi=%b lo=%b expected complementary", i, gate_hi0, gate_lo0);
      end
    end
    checks++;
    if (hi_cnt != 7) begin errors++; $display("FAIL compl_hi_count: got %0d expected 7", hi_cnt); end
    checks++;
    if (lo_cnt != 9) begin errors++; $display("FAIL compl_lo_count: got %0d expected 9", lo_cnt); end
  endtask

  task automatic test_deadtime();
    logic [12:0] vals [12] = '{13'd0, 13'd0, 13'd8191, 13'd8191, 13'd8191, 13'd8191,
                               13'd8191, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
    logic        ehi  [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        elo  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    force_mode = 1'b1; force_val = 13'd8191;
    repeat (6) step();
    checks++;
    if ({gate_hi, gate_lo} !== 2'b10) begin errors++; $display("FAIL dt_settle: got %b expected 10", {gate_hi, gate_lo}); end
    for (int i = 0; i < 12; i++) begin
      force_val = vals[i];
      step();
      checks++;
      if ({gate_hi, gate_lo} !== {ehi[i], elo[i]}) begin
        errors++; $display("FAIL dt_step i=%0d: got %b expected %b", i, {gate_hi, gate_lo}, {ehi[i], elo[i]});
      end
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    force_mode = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 2849; k++) begin
      step();
      if (period_done === 1'b1) pulses++;
      if (k == 1423 || k == 2847) begin
        checks++;
        if (teth_ta !== 10'd88 || polarity !== ((k == 1423) ? 1'b0 : 1'b1)) begin
          errors++; $display("FAIL wrap_pre k=%0d: got ta=%0d pol=%b", k, teth_ta, polarity);
        end
      end
      if (k == 1424) begin
        checks++;
        if ({teth_ta, polarity, period_done} !== {10'd0, 1'b1, 1'b0}) begin
          errors++; $display("FAIL wrap1: got ta=%0d pol=%b pd=%b expected ta=0 pol=1 pd=0", teth_ta, polarity, period_done);
        end
      end
      if (k == 2848) begin
        checks++;
        if ({teth_ta, polarity, period_done} !== {10'd0, 1'b0, 1'b1}) begin
          errors++; $display("FAIL wrap2: got ta=%0d pol=%b pd=%b expected ta=0 pol=0 pd=1", teth_ta, polarity, period_done);
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL period_done_count: got %0d expected 1", pulses); end
  endtask

  task automatic test_freeze();
    logic [9:0]  frz_ta;
    logic [12:0] frz_c;
    int          bad = 0;
    int          d;
    force_mode = 1'b1; force_val = 13'd8191;
    repeat (5) step();
    checks++;
    if ({gate_hi, gate_lo} !== 2'b10) begin errors++; $display("FAIL frz_pre: got %b expected 10", {gate_hi, gate_lo}); end
    frz_ta = teth_ta; frz_c = dut.carrier;
    en = 1'b0;
    step();
    checks++;
    if ({gate_hi, gate_lo} !== 2'b00) begin errors++; $display("FAIL frz_gates: got %b expected 00", {gate_hi, gate_lo}); end
    for (int i = 0; i < 20; i++) begin
      if (teth_ta !== frz_ta || dut.carrier !== frz_c || gate_hi !== 1'b0 || gate_lo !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL frz_hold: got %0d bad cycles expected 0", bad); end
    en = 1'b1;
    step();
    d = int'(dut.carrier) - int'(frz_c);
    checks++;
    if ((d != 1 && d != -1) || gate_hi !== 1'b0) begin
      errors++; $display("FAIL frz_resume: got carrier=%0d from %0d hi=%b expected step 1 hi=0", dut.carrier, frz_c, gate_hi);
    end
    step();
    checks++;
    if ({gate_hi, gate_lo} !== 2'b10) begin errors++; $display("FAIL frz_first_gate: got %b expected 10", {gate_hi, gate_lo}); end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    force_mode = 1'b0;
    while (!(teth_ta === 10'd40 && polarity === 1'b1) && budget < 4000) begin step(); budget++; end
    while (dut.carrier !== 13'd5 && budget < 4020) begin step(); budget++; end
    checks++;
    if (budget >= 4000) begin
      errors++; $display("FAIL rstmid_reach: got ta=%0d pol=%b expected ta=40 pol=1 within budget", teth_ta, polarity);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({teth_ta, polarity, gate_hi, gate_lo, period_done} !== {10'd0, 4'b0000}) begin
      errors++; $display("FAIL rstmid_outputs: got ta=%0d pol=%b hi=%b lo=%b pd=%b expected all 0",
                         teth_ta, polarity, gate_hi, gate_lo, period_done);
    end
    checks++;
    if (dut.carrier !== 13'd0) begin errors++; $display("FAIL rstmid_carrier: got %0d expected 0", dut.carrier); end
    rst = 1'b0;
    step();
    checks++;
    if (dut.carrier !== 13'd1) begin errors++; $display("FAIL rstmid_up: got %0d expected 1", dut.carrier); end
  endtask

  initial begin
    test_reset();
    test_complementary();
    test_deadtime();
    test_wrap();
    test_freeze();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
